// File: rtl/sat_pkg.sv
// sat_pkg: shared SAT literal value and variable state types plus var_value packing.
// Types:    lit_val_t   2-bit literal value (FREE/FALSE/TRUE/CONFLICT), matches lit cell var_value[2:1]
//           var_state_t variable cell FSM state
// Function: pack_var_value(value, implied) -> {value[1:0], implied}
package sat_pkg;
    typedef enum logic [1:0] {
        LV_FREE     = 2'd0,
        LV_FALSE    = 2'd1,
        LV_TRUE     = 2'd2,
        LV_CONFLICT = 2'd3
    } lit_val_t;

    typedef enum logic [1:0] {
        ST_FREE,
        ST_ASSIGNED,
        ST_CONFLICT
    } var_state_t;

    function automatic logic [2:0] pack_var_value(input lit_val_t value, input logic implied);
        return {value, implied};
    endfunction
endpackage

// File: rtl/imp_collect.sv
// imp_collect: reduces per-lit implication requests to polarity flags and lowest-index reasons.
// Macro:  REASON_TRACK_EN adds the reason outputs (priority encoders); absent, only polarity flags exist.
// Ports:  imp_req_i  [NUM_LITS] per-lit request
//         imp_val_i  [NUM_LITS] per-lit requested value (1=true)
//         any_true_o / any_false_o  some lit requests true / false
//         reason_true_o / reason_false_o / reason_any_o  lowest requesting lit of each kind (macro only)
module imp_collect #(
    parameter int NUM_LITS = 8,
    parameter int RW = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1
) (
    input  logic [NUM_LITS-1:0] imp_req_i,
    input  logic [NUM_LITS-1:0] imp_val_i,
    output logic                any_true_o,
`ifdef REASON_TRACK_EN
    output logic [RW-1:0]       reason_true_o,
    output logic [RW-1:0]       reason_false_o,
    output logic [RW-1:0]       reason_any_o,
`endif
    output logic                any_false_o
);
    logic [NUM_LITS-1:0] req_t, req_f;

    assign req_t       = imp_req_i & imp_val_i;
    assign req_f       = imp_req_i & ~imp_val_i;
    assign any_true_o  = |req_t;
    assign any_false_o = |req_f;

`ifdef REASON_TRACK_EN
    // Scanning from the top down leaves the lowest set index as the result.
    function automatic logic [RW-1:0] lowest(input logic [NUM_LITS-1:0] v);
        lowest = '0;
        for (int i = NUM_LITS - 1; i >= 0; i--)
            if (v[i]) lowest = RW'(i);
    endfunction

    assign reason_true_o  = lowest(req_t);
    assign reason_false_o = lowest(req_f);
    assign reason_any_o   = lowest(imp_req_i);
`endif
endmodule

// File: rtl/var_cell.sv
// var_cell: variable-side end of the lit interface; holds value, level and implied flag of one SAT variable.
// Macro:  REASON_TRACK_EN registers the lowest-index implying lit on reason_o; absent, reason_o is 0.
// Ports:  clk, rst (async, active low)
//         wr_i/wr_value_i/wr_level_i       host load
//         cur_level_i                      current decision level
//         decide_i/decide_phase_i          decision strobe and phase (1=true)
//         imp_req_i/imp_val_i              per-lit implication requests
//         backtrack_i/bkt_level_i          backtrack strobe and target level
//         var_value_o {value,implied}, level_o, conflict_o, assigned_o (FREE->ASSIGNED pulse), reason_o
module var_cell
    import sat_pkg::*;
#(
    parameter int NUM_LITS = 8,
    parameter int LVL_W = 8,
    parameter int RW = (NUM_LITS > 1) ? $clog2(NUM_LITS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_i,
    input  logic [1:0]          wr_value_i,
    input  logic [LVL_W-1:0]    wr_level_i,
    input  logic [LVL_W-1:0]    cur_level_i,
    input  logic                decide_i,
    input  logic                decide_phase_i,
    input  logic [NUM_LITS-1:0] imp_req_i,
    input  logic [NUM_LITS-1:0] imp_val_i,
    input  logic                backtrack_i,
    input  logic [LVL_W-1:0]    bkt_level_i,
    output logic [2:0]          var_value_o,
    output logic [LVL_W-1:0]    level_o,
    output logic                conflict_o,
    output logic                assigned_o,
    output logic [RW-1:0]       reason_o
);
    var_state_t       state_q, state_d;
    lit_val_t         value_q, value_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             implied_q, implied_d;
    logic             assigned_q, assigned_d;
    logic             any_true, any_false;
    logic [RW-1:0]    rsn_t, rsn_f, rsn_any;
    logic [RW-1:0]    reason_q, reason_d;

    imp_collect #(.NUM_LITS(NUM_LITS), .RW(RW)) u_collect (
        .imp_req_i      (imp_req_i),
        .imp_val_i      (imp_val_i),
        .any_true_o     (any_true),
`ifdef REASON_TRACK_EN
        .reason_true_o  (rsn_t),
        .reason_false_o (rsn_f),
        .reason_any_o   (rsn_any),
`endif
        .any_false_o    (any_false)
    );

`ifndef REASON_TRACK_EN
    assign rsn_t   = '0;
    assign rsn_f   = '0;
    assign rsn_any = '0;
`endif

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        level_d    = level_q;
        implied_d  = implied_q;
        assigned_d = 1'b0;
        reason_d   = reason_q;
        if (wr_i) begin
            value_d   = lit_val_t'(wr_value_i);
            level_d   = wr_level_i;
            implied_d = 1'b0;
            reason_d  = '0;
            state_d   = (wr_value_i == LV_FREE)     ? ST_FREE :
                        (wr_value_i == LV_CONFLICT) ? ST_CONFLICT : ST_ASSIGNED;
        end else if (backtrack_i) begin
            if (state_q == ST_CONFLICT || (state_q == ST_ASSIGNED && level_q > bkt_level_i)) begin
                state_d   = ST_FREE;
                value_d   = LV_FREE;
                level_d   = '0;
                implied_d = 1'b0;
                reason_d  = '0;
            end
        end else if (state_q == ST_FREE) begin
            if (decide_i) begin
                state_d    = ST_ASSIGNED;
                value_d    = decide_phase_i ? LV_TRUE : LV_FALSE;
                level_d    = cur_level_i;
                implied_d  = 1'b0;
                assigned_d = 1'b1;
                reason_d   = '0;
            end else if (any_true && any_false) begin
                state_d   = ST_CONFLICT;
                value_d   = LV_CONFLICT;
                level_d   = cur_level_i;
                implied_d = 1'b0;
                reason_d  = rsn_any;
            end else if (any_true || any_false) begin
                state_d    = ST_ASSIGNED;
                value_d    = any_true ? LV_TRUE : LV_FALSE;
                level_d    = cur_level_i;
                implied_d  = 1'b1;
                assigned_d = 1'b1;
                reason_d   = any_true ? rsn_t : rsn_f;
            end
        end else if (state_q == ST_ASSIGNED) begin
            // Only a request against the held value matters; the level is kept.
            if (value_q == LV_TRUE ? any_false : any_true) begin
                state_d   = ST_CONFLICT;
                value_d   = LV_CONFLICT;
                implied_d = 1'b0;
                reason_d  = (value_q == LV_TRUE) ? rsn_f : rsn_t;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_FREE;
            value_q    <= LV_FREE;
            level_q    <= '0;
            implied_q  <= 1'b0;
            assigned_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            level_q    <= level_d;
            implied_q  <= implied_d;
            assigned_q <= assigned_d;
        end
    end

`ifdef REASON_TRACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) reason_q <= '0;
        else      reason_q <= reason_d;
    end
    assign reason_o = reason_q;
`else
    assign reason_q = '0;
    assign reason_o = '0;
`endif

    assign var_value_o = pack_var_value(value_q, implied_q);
    assign level_o     = level_q;
    assign conflict_o  = (state_q == ST_CONFLICT);
    assign assigned_o  = assigned_q;
endmodule

// File: tb/tb_var_cell.sv
// tb_var_cell: table-driven self-checking bench for var_cell with an expectation queue.
module tb_var_cell;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_i = 1'b0;
    logic [1:0] wr_value_i = '0;
    logic [7:0] wr_level_i = '0;
    logic [7:0] cur_level_i = '0;
    logic       decide_i = 1'b0;
    logic       decide_phase_i = 1'b0;
    logic [7:0] imp_req_i = '0;
    logic [7:0] imp_val_i = '0;
    logic       backtrack_i = 1'b0;
    logic [7:0] bkt_level_i = '0;
    logic [2:0] var_value_o;
    logic [7:0] level_o;
    logic       conflict_o;
    logic       assigned_o;
    logic [2:0] reason_o;

    int checks = 0;
    int errors = 0;

    var_cell #(.NUM_LITS(8), .LVL_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_i(wr_i), .wr_value_i(wr_value_i), .wr_level_i(wr_level_i),
        .cur_level_i(cur_level_i),
        .decide_i(decide_i), .decide_phase_i(decide_phase_i),
        .imp_req_i(imp_req_i), .imp_val_i(imp_val_i),
        .backtrack_i(backtrack_i), .bkt_level_i(bkt_level_i),
        .var_value_o(var_value_o), .level_o(level_o), .conflict_o(conflict_o),
        .assigned_o(assigned_o), .reason_o(reason_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [1:0] wv;
        logic [7:0] wl;
        logic [7:0] cl;
        logic       dec;
        logic       ph;
        logic [7:0] rq;
        logic [7:0] rv;
        logic       bt;
        logic [7:0] bl;
        logic [2:0] vv;
        logic [2:0] msk;
        logic [7:0] lv;
        logic       cf;
        logic       as;
        logic [2:0] rs;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] vv;
        logic [2:0] msk;
        logic [7:0] lv;
        logic       cf;
        logic       as;
        logic [2:0] rs;
    } exp_t;

    vec_t tbl[24];
    exp_t sb[$];

    function automatic vec_t mk(logic wr, logic [1:0] wv, logic [7:0] wl, logic [7:0] cl,
                                logic dec, logic ph, logic [7:0] rq, logic [7:0] rv,
                                logic bt, logic [7:0] bl, logic [2:0] vv, logic [2:0] msk,
                                logic [7:0] lv, logic cf, logic as, logic [2:0] rs);
        vec_t v;
        v.wr = wr; v.wv = wv; v.wl = wl; v.cl = cl; v.dec = dec; v.ph = ph;
        v.rq = rq; v.rv = rv; v.bt = bt; v.bl = bl; v.vv = vv; v.msk = msk;
        v.lv = lv; v.cf = cf; v.as = as; v.rs = rs;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, req);
        end
    endtask

    task automatic idle();
        wr_i = 0; decide_i = 0; backtrack_i = 0; imp_req_i = '0; imp_val_i = '0;
    endtask

    task automatic compare_head();
        exp_t e;
        logic [2:0] er;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
`ifdef REASON_TRACK_EN
        er = e.rs;
`else
        er = 3'd0;
`endif
        chk("var_value", e.idx, 32'(var_value_o & e.msk), 32'(e.vv & e.msk));
        chk("level", e.idx, 32'(level_o), 32'(e.lv));
        chk("conflict", e.idx, 32'(conflict_o), 32'(e.cf));
        chk("assigned", e.idx, 32'(assigned_o), 32'(e.as));
        chk("reason", e.idx, 32'(reason_o), 32'(er));
    endtask

    initial begin
        //           wr wv  wl     cl     dec ph rq     rv     bt bl     vv      msk     lv     cf as rs
        tbl[0]  = mk(0, 0, 8'd0,  8'd3,  1, 1, 8'h00, 8'h00, 0, 8'd0,  3'b100, 3'b111, 8'd3,  0, 1, 0);
        tbl[1]  = mk(0, 0, 8'd0,  8'd3,  0, 0, 8'h00, 8'h00, 0, 8'd0,  3'b100, 3'b111, 8'd3,  0, 0, 0);
        tbl[2]  = mk(0, 0, 8'd0,  8'd9,  1, 0, 8'h00, 8'h00, 0, 8'd0,  3'b100, 3'b111, 8'd3,  0, 0, 0);
        tbl[3]  = mk(0, 0, 8'd0,  8'd3,  0, 0, 8'h00, 8'h00, 1, 8'd3,  3'b100, 3'b111, 8'd3,  0, 0, 0);
        tbl[4]  = mk(0, 0, 8'd0,  8'd3,  0, 0, 8'h00, 8'h00, 1, 8'd2,  3'b000, 3'b111, 8'd0,  0, 0, 0);
        tbl[5]  = mk(0, 0, 8'd0,  8'd2,  0, 0, 8'h10, 8'h10, 0, 8'd0,  3'b101, 3'b111, 8'd2,  0, 1, 4);
        tbl[6]  = mk(0, 0, 8'd0,  8'd2,  0, 0, 8'h01, 8'h00, 0, 8'd0,  3'b110, 3'b110, 8'd2,  1, 0, 0);
        tbl[7]  = mk(0, 0, 8'd0,  8'd4,  1, 1, 8'h03, 8'h01, 0, 8'd0,  3'b110, 3'b110, 8'd2,  1, 0, 0);
        tbl[8]  = mk(0, 0, 8'd0,  8'd0,  0, 0, 8'h00, 8'h00, 1, 8'd7,  3'b000, 3'b111, 8'd0,  0, 0, 0);
        tbl[9]  = mk(0, 0, 8'd0,  8'd5,  0, 0, 8'h0C, 8'h04, 0, 8'd0,  3'b110, 3'b110, 8'd5,  1, 0, 2);
        tbl[10] = mk(1, 2, 8'd5,  8'd0,  0, 0, 8'h00, 8'h00, 0, 8'd0,  3'b100, 3'b111, 8'd5,  0, 0, 0);
        tbl[11] = mk(0, 0, 8'd0,  8'd0,  0, 0, 8'h00, 8'h00, 1, 8'd5,  3'b100, 3'b111, 8'd5,  0, 0, 0);
        tbl[12] = mk(0, 0, 8'd0,  8'd0,  0, 0, 8'h00, 8'h00, 1, 8'd4,  3'b000, 3'b111, 8'd0,  0, 0, 0);
        tbl[13] = mk(0, 0, 8'd0,  8'd1,  0, 0, 8'h60, 8'h00, 0, 8'd0,  3'b011, 3'b111, 8'd1,  0, 1, 5);
        tbl[14] = mk(0, 0, 8'd0,  8'd6,  0, 0, 8'h80, 8'h00, 0, 8'd0,  3'b011, 3'b111, 8'd1,  0, 0, 5);
        tbl[15] = mk(0, 0, 8'd0,  8'd6,  0, 0, 8'h84, 8'h80, 0, 8'd0,  3'b110, 3'b110, 8'd1,  1, 0, 7);
        tbl[16] = mk(1, 1, 8'd7,  8'd2,  1, 1, 8'h00, 8'h00, 1, 8'd0,  3'b010, 3'b111, 8'd7,  0, 0, 0);
        tbl[17] = mk(1, 3, 8'd9,  8'd0,  0, 0, 8'h00, 8'h00, 0, 8'd0,  3'b110, 3'b111, 8'd9,  1, 0, 0);
        tbl[18] = mk(1, 0, 8'd4,  8'd0,  0, 0, 8'h00, 8'h00, 0, 8'd0,  3'b000, 3'b111, 8'd4,  0, 0, 0);
        tbl[19] = mk(0, 0, 8'd0,  8'd6,  1, 0, 8'h01, 8'h01, 0, 8'd0,  3'b010, 3'b111, 8'd6,  0, 1, 0);
        tbl[20] = mk(0, 0, 8'd0,  8'd0,  0, 0, 8'h00, 8'h00, 1, 8'hFF, 3'b010, 3'b111, 8'd6,  0, 0, 0);
        tbl[21] = mk(0, 0, 8'd0,  8'd0,  0, 0, 8'h00, 8'h00, 1, 8'd0,  3'b000, 3'b111, 8'd0,  0, 0, 0);
        tbl[22] = mk(1, 2, 8'h80, 8'd0,  0, 0, 8'h00, 8'h00, 0, 8'd0,  3'b100, 3'b111, 8'h80, 0, 0, 0);
        tbl[23] = mk(0, 0, 8'd0,  8'd0,  0, 0, 8'h00, 8'h00, 1, 8'h7F, 3'b000, 3'b111, 8'd0,  0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_value", -1, 32'(var_value_o), 32'd0);
        chk("reset_level", -1, 32'(level_o), 32'd0);
        chk("reset_conflict", -1, 32'(conflict_o), 32'd0);
        chk("reset_assigned", -1, 32'(assigned_o), 32'd0);
        chk("reset_reason", -1, 32'(reason_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            wr_i = tbl[i].wr; wr_value_i = tbl[i].wv; wr_level_i = tbl[i].wl;
            cur_level_i = tbl[i].cl; decide_i = tbl[i].dec; decide_phase_i = tbl[i].ph;
            imp_req_i = tbl[i].rq; imp_val_i = tbl[i].rv;
            backtrack_i = tbl[i].bt; bkt_level_i = tbl[i].bl;
            sb.push_back('{i, tbl[i].vv, tbl[i].msk, tbl[i].lv, tbl[i].cf, tbl[i].as, tbl[i].rs});
            @(posedge clk);
            #1;
            compare_head();
        end

        // Async reset while ASSIGNED clears outputs without waiting for a clock edge.
        @(negedge clk);
        idle();
        cur_level_i = 8'd5; decide_i = 1; decide_phase_i = 1;
        @(posedge clk);
        #1;
        chk("pre_reset_value", 100, 32'(var_value_o), 32'h4);
        @(negedge clk);
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_value", 101, 32'(var_value_o), 32'd0);
        chk("async_reset_level", 101, 32'(level_o), 32'd0);
        chk("async_reset_conflict", 101, 32'(conflict_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Held decide strobe gives exactly one assigned_o pulse.
        @(negedge clk);
        cur_level_i = 8'd3; decide_i = 1; decide_phase_i = 1;
        begin
            int pulses = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                if (assigned_o) pulses++;
            end
            chk("assigned_pulses", 102, 32'(pulses), 32'd1);
            chk("decide_level", 102, 32'(level_o), 32'd3);
        end
        @(negedge clk);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
